// File: rtl/phase_sequencer_pkg.sv
// Shared timing definitions for the phase sequencer and the control unit that decodes its phases.
package phase_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_HALT = 2'd2
    } seq_state_t;

    localparam int DEF_NPHASE = 4;
    localparam int DEF_IR_PH  = 1;
    localparam int DEF_CNT_W  = 16;

    function automatic int ph_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/phase_sequencer_onehot_to_bin.sv
// One-hot to binary index encoder; an all-zero input yields index 0.
module onehot_to_bin #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_onehot,
    output logic [W-1:0] o_idx
);

    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (i_onehot[i]) o_idx |= W'(i);
        end
    end

endmodule

// File: rtl/phase_sequencer.sv
// CPU machine-cycle timing generator: one-hot phase ring with fetch/PC strobes,
// stall, early cycle end, halt/resume and a retired-cycle counter.
//
// state    | meaning
// SEQ_IDLE | after reset; pc_en primes the first fetch address
// SEQ_RUN  | phase ring active, r_phase exactly one-hot
// SEQ_HALT | parked at a cycle boundary until halt_req drops
module phase_sequencer
    import phase_sequencer_pkg::*;
#(
    parameter  int NPHASE = DEF_NPHASE,
    parameter  int IR_PH  = DEF_IR_PH,
    parameter  int CNT_W  = DEF_CNT_W,
    localparam int PH_W   = ph_width(NPHASE)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_stall,
    input  logic              i_early_end,
    input  logic              i_halt_req,
    output logic [NPHASE-1:0] o_phase,
    output logic [PH_W-1:0]   o_phase_idx,
    output logic              o_ir_en,
    output logic              o_pc_en,
    output logic              o_cyc_end,
    output logic              o_halted,
    output logic [CNT_W-1:0]  o_cycle_cnt
);

    localparam logic [NPHASE-1:0] PH_FIRST = NPHASE'(1);
    localparam logic [PH_W-1:0]   IR_IDX   = PH_W'(IR_PH);

    seq_state_t        r_state, w_state_nxt;
    logic [NPHASE-1:0] r_phase, w_phase_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic [PH_W-1:0]   w_idx;
    logic              w_boundary;

    onehot_to_bin #(.N(NPHASE), .W(PH_W)) u_enc (
        .i_onehot (r_phase),
        .o_idx    (w_idx)
    );

    // r_phase is zero outside RUN, so the boundary term is inert in IDLE/HALT.
    assign w_boundary = r_phase[NPHASE-1] | (i_early_end & (w_idx > IR_IDX));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= SEQ_IDLE;
            r_phase <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            SEQ_IDLE: begin
                w_state_nxt = SEQ_RUN;
                w_phase_nxt = PH_FIRST;
            end
            SEQ_RUN: begin
                if (!i_stall) begin
                    if (w_boundary) begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (i_halt_req) begin
                            w_state_nxt = SEQ_HALT;
                            w_phase_nxt = '0;
                        end else begin
                            w_phase_nxt = PH_FIRST;
                        end
                    end else begin
                        w_phase_nxt = {r_phase[NPHASE-2:0], 1'b0};
                    end
                end
            end
            SEQ_HALT: begin
                if (!i_halt_req) begin
                    w_state_nxt = SEQ_RUN;
                    w_phase_nxt = PH_FIRST;
                end
            end
            default: begin
                w_state_nxt = SEQ_IDLE;
                w_phase_nxt = '0;
            end
        endcase
    end

    always_comb begin
        o_ir_en   = 1'b0;
        o_pc_en   = 1'b0;
        o_cyc_end = 1'b0;
        o_halted  = 1'b0;
        case (r_state)
            SEQ_IDLE: o_pc_en = 1'b1;
            SEQ_RUN: begin
                if (!i_stall) begin
                    o_ir_en   = r_phase[IR_PH];
                    o_pc_en   = w_boundary;
                    o_cyc_end = w_boundary;
                end
            end
            SEQ_HALT: o_halted = 1'b1;
            default: ;
        endcase
    end

    assign o_phase     = r_phase;
    assign o_phase_idx = w_idx;
    assign o_cycle_cnt = r_cnt;

    a_run_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (r_state == SEQ_RUN) |-> $onehot(r_phase));

endmodule
